countdown_mod_m: RTL and testbench

Loadable down-counter that is the counterpart of the free-running mod-M up-counter. It takes a start value from a requester, counts it down to zero on qualified enable ticks, and signals completion with a one-cycle done pulse. It serves as the timeout/interval source for control FSMs, with optional periodic (auto-reload) operation.

---
 rtl/countdown_mod_m_if.sv | 34 +++
 rtl/countdown_mod_m.sv | 152 +++++++++++++++
 tb/tb_countdown_mod_m.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/countdown_mod_m_if.sv
// Request/status bundle for the loadable mod-M down-counter.
// The requester side (master) drives start/load/enable/abort and observes
// the count, busy and done; the counter itself sits on the slave side.
interface countdown_mod_m_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] load_val;
  logic         enable;
  logic         abort;
  logic [N-1:0] Q;
  logic         busy;
  logic         done;

  modport master (
    output start,
    output load_val,
    output enable,
    output abort,
    input  Q,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  load_val,
    input  enable,
    input  abort,
    output Q,
    output busy,
    output done
  );
endinterface

// File: rtl/countdown_mod_m.sv
// Loadable mod-M down-counter used as a timeout / interval source.
// A start in IDLE captures a (clamped) value that is then counted down on
// enable ticks. When the count reaches zero, done pulses for one cycle.
// With AUTO_RELOAD=1 the counter stays in RUN and re-arms from the captured
// value on the next enable tick, giving a period of reload+1 ticks.
// Reset is synchronous and active-low. Every output comes straight from a flop.
module countdown_mod_m #(
  parameter int M           = 10,
  parameter int AUTO_RELOAD = 0
) (
  input  logic               clk,
  input  logic               aclr,
  countdown_mod_m_if.slave   bus
);

  // Number of bits needed to represent value, never less than one.
  function automatic int clogb2(input int value);
    int r;
    r = 32'sd0;
    for (int v = value; v > 32'sd0; v = v >>> 1) begin
      r = r + 32'sd1;
    end
    if (r == 32'sd0) begin
      r = 32'sd1;
    end else begin
      r = r;
    end
    return r;
  endfunction

  localparam int           N      = clogb2(M - 1);
  localparam logic [N-1:0] MAX_Q  = N'(M - 1);
  localparam logic [N-1:0] ZERO_Q = {N{1'b0}};
  localparam logic [N-1:0] ONE_Q  = N'(32'd1);
  localparam logic         PERIODIC = (AUTO_RELOAD != 0);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t       state_r;
  state_t       state_next_s;
  logic [N-1:0] q_r;
  logic [N-1:0] q_next_s;
  logic [N-1:0] reload_r;
  logic [N-1:0] reload_next_s;
  logic         done_r;
  logic         done_next_s;
  logic         busy_r;
  logic [N-1:0] lv_s;

  // Clamp the requested start value into the legal range 0..M-1.
  always_comb begin
    lv_s = bus.load_val;
    if (bus.load_val > MAX_Q) begin
      lv_s = MAX_Q;
    end else begin
      lv_s = bus.load_val;
    end
  end

  // Next-state, next-count and done-pulse decode; priority abort > start > enable.
  always_comb begin
    state_next_s  = state_r;
    q_next_s      = q_r;
    reload_next_s = reload_r;
    done_next_s   = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus.abort) begin
          // Nothing is running, so an abort just masks any start request.
          state_next_s = ST_IDLE;
        end else if (bus.start) begin
          if (lv_s == ZERO_Q) begin
            // Zero-length request completes immediately without ever going busy.
            q_next_s    = ZERO_Q;
            done_next_s = 1'b1;
          end else begin
            q_next_s      = lv_s;
            reload_next_s = lv_s;
            state_next_s  = ST_RUN;
          end
        end else begin
          // Idle and no request: count holds, enable is ignored.
          q_next_s = q_r;
        end
      end

      ST_RUN: begin
        if (bus.abort) begin
          // Silent cancel: no done, captured period thrown away.
          q_next_s      = ZERO_Q;
          reload_next_s = ZERO_Q;
          state_next_s  = ST_IDLE;
        end else if (bus.enable) begin
          if (q_r > ONE_Q) begin
            q_next_s = q_r - ONE_Q;
          end else if (q_r == ONE_Q) begin
            q_next_s    = ZERO_Q;
            done_next_s = 1'b1;
            if (PERIODIC) begin
              state_next_s = ST_RUN;
            end else begin
              state_next_s = ST_IDLE;
            end
          end else begin
            // Q is zero in RUN only in periodic mode: re-arm without a done.
            if (PERIODIC) begin
              q_next_s = reload_r;
            end else begin
              q_next_s     = ZERO_Q;
              state_next_s = ST_IDLE;
            end
          end
        end else begin
          // No tick this cycle: everything holds. start is ignored in RUN.
          q_next_s = q_r;
        end
      end

      default: begin
        state_next_s  = ST_IDLE;
        q_next_s      = ZERO_Q;
        reload_next_s = ZERO_Q;
      end
    endcase
  end

  // State, count, reload and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!aclr) begin
      state_r  <= ST_IDLE;
      q_r      <= ZERO_Q;
      reload_r <= ZERO_Q;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      q_r      <= q_next_s;
      reload_r <= reload_next_s;
      done_r   <= done_next_s;
      busy_r   <= (state_next_s == ST_RUN);
    end
  end

  assign bus.Q    = q_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_countdown_mod_m.sv
// Self-checking bench for countdown_mod_m: a one-shot and a periodic
// instance (M=10) share the same stimulus. Hand-written vector tables cover
// the directed scenarios; a randomized phase compares both instances with a
// behavioural model of the counting rules.
module tb_countdown_mod_m;

  localparam int M = 10;
  localparam int N = 4;

  typedef struct {
    logic         aclr;
    logic         start;
    logic [N-1:0] load;
    logic         en;
    logic         abort;
    int           q;
    logic         busy;
    logic         done;
  } vec_t;

  logic clk = 1'b0;
  logic aclr;

  countdown_mod_m_if #(.N(N)) bus0 ();
  countdown_mod_m_if #(.N(N)) bus1 ();

  countdown_mod_m #(.M(M), .AUTO_RELOAD(0)) dut0 (.clk(clk), .aclr(aclr), .bus(bus0));
  countdown_mod_m #(.M(M), .AUTO_RELOAD(1)) dut1 (.clk(clk), .aclr(aclr), .bus(bus1));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // behavioural model state, index 0 = one-shot, 1 = periodic
  int m_q    [2];
  bit m_run  [2];
  int m_rel  [2];
  bit m_done [2];

  vec_t tbl_one[$];
  vec_t tbl_auto[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Counting rules applied to one model instance for the inputs just sampled.
  task automatic model_step(input int k, input bit periodic,
                            input logic a, input logic s, input int lv_raw,
                            input logic e, input logic ab);
    int lv;
    lv = (lv_raw > M - 1) ? M - 1 : lv_raw;
    if (!a) begin
      m_q[k] = 0; m_run[k] = 0; m_rel[k] = 0; m_done[k] = 0;
    end else begin
      m_done[k] = 0;
      if (m_run[k]) begin
        if (ab) begin
          m_q[k] = 0; m_run[k] = 0; m_rel[k] = 0;
        end else if (e) begin
          if (m_q[k] == 0) begin
            m_q[k] = m_rel[k];
          end else begin
            m_q[k] = m_q[k] - 1;
            if (m_q[k] == 0) begin
              m_done[k] = 1;
              if (!periodic) m_run[k] = 0;
            end
          end
        end
      end else if (!ab && s) begin
        if (lv == 0) begin
          m_q[k] = 0; m_done[k] = 1;
        end else begin
          m_q[k] = lv; m_rel[k] = lv; m_run[k] = 1;
        end
      end
    end
  endtask

  // Drive both instances, clock once, advance the models, compare.
  task automatic apply(input logic a, input logic s, input logic [N-1:0] lv,
                       input logic e, input logic ab, input bit chk0);
    aclr = a;
    bus0.start = s; bus0.load_val = lv; bus0.enable = e; bus0.abort = ab;
    bus1.start = s; bus1.load_val = lv; bus1.enable = e; bus1.abort = ab;
    @(posedge clk);
    model_step(0, 1'b0, a, s, int'(lv), e, ab);
    model_step(1, 1'b1, a, s, int'(lv), e, ab);
    #1;
    check("model1.Q",    32'(bus1.Q),    32'(m_q[1]));
    check("model1.busy", 32'(bus1.busy), 32'(m_run[1]));
    check("model1.done", 32'(bus1.done), 32'(m_done[1]));
    if (chk0) begin
      check("model0.Q",    32'(bus0.Q),    32'(m_q[0]));
      check("model0.busy", 32'(bus0.busy), 32'(m_run[0]));
      check("model0.done", 32'(bus0.done), 32'(m_done[0]));
    end
  endtask

  function automatic vec_t mk(input logic a, input logic s, input int lv, input logic e,
                              input logic ab, input int q, input logic b, input logic d);
    vec_t v;
    v.aclr = a; v.start = s; v.load = N'(lv); v.en = e; v.abort = ab;
    v.q = q; v.busy = b; v.done = d;
    return v;
  endfunction

  initial begin
    aclr = 1'b0;
    bus0.start = 1'b0; bus0.load_val = '0; bus0.enable = 1'b0; bus0.abort = 1'b0;
    bus1.start = 1'b0; bus1.load_val = '0; bus1.enable = 1'b0; bus1.abort = 1'b0;

    // one-shot instance: {aclr,start,load,en,abort} -> {Q,busy,done}
    // reset with start/enable active, then nothing happens without a new start
    tbl_one.push_back(mk(0,1,5,1,0, 0,0,0));
    tbl_one.push_back(mk(0,1,5,1,0, 0,0,0));
    tbl_one.push_back(mk(1,0,5,1,0, 0,0,0));
    tbl_one.push_back(mk(1,0,5,1,0, 0,0,0));
    // load 3: Q=3,2,1,0 with done/busy-low in the last cycle
    tbl_one.push_back(mk(1,1,3,1,0, 3,1,0));
    tbl_one.push_back(mk(1,0,0,1,0, 2,1,0));
    tbl_one.push_back(mk(1,0,0,1,0, 1,1,0));
    tbl_one.push_back(mk(1,0,0,1,0, 0,0,1));
    tbl_one.push_back(mk(1,0,0,1,0, 0,0,0));
    // clamp: load 15 -> 9, done after 9 enables
    tbl_one.push_back(mk(1,1,15,1,0, 9,1,0));
    for (int i = 8; i >= 1; i--) tbl_one.push_back(mk(1,0,0,1,0, i,1,0));
    tbl_one.push_back(mk(1,0,0,1,0, 0,0,1));
    tbl_one.push_back(mk(1,0,0,1,0, 0,0,0));
    // zero load: immediate done, never busy
    tbl_one.push_back(mk(1,1,0,1,0, 0,0,1));
    tbl_one.push_back(mk(1,0,0,1,0, 0,0,0));
    // enable gaps 1,0,0,1,1,0,1 with a start pulse mid-count
    tbl_one.push_back(mk(1,1,4,0,0, 4,1,0));
    tbl_one.push_back(mk(1,0,0,1,0, 3,1,0));
    tbl_one.push_back(mk(1,1,9,0,0, 3,1,0));
    tbl_one.push_back(mk(1,0,0,0,0, 3,1,0));
    tbl_one.push_back(mk(1,0,0,1,0, 2,1,0));
    tbl_one.push_back(mk(1,0,0,1,0, 1,1,0));
    tbl_one.push_back(mk(1,0,0,0,0, 1,1,0));
    tbl_one.push_back(mk(1,0,0,1,0, 0,0,1));
    tbl_one.push_back(mk(1,0,0,0,0, 0,0,0));
    // abort at Q=3
    tbl_one.push_back(mk(1,1,6,1,0, 6,1,0));
    tbl_one.push_back(mk(1,0,0,1,0, 5,1,0));
    tbl_one.push_back(mk(1,0,0,1,0, 4,1,0));
    tbl_one.push_back(mk(1,0,0,1,0, 3,1,0));
    tbl_one.push_back(mk(1,0,0,1,1, 0,0,0));
    tbl_one.push_back(mk(1,0,0,1,0, 0,0,0));
    // reset at Q=3
    tbl_one.push_back(mk(1,1,6,1,0, 6,1,0));
    tbl_one.push_back(mk(1,0,0,1,0, 5,1,0));
    tbl_one.push_back(mk(1,0,0,1,0, 4,1,0));
    tbl_one.push_back(mk(1,0,0,1,0, 3,1,0));
    tbl_one.push_back(mk(0,0,0,1,0, 0,0,0));
    tbl_one.push_back(mk(1,0,0,1,0, 0,0,0));
    // abort beats start in IDLE; abort beats the final tick
    tbl_one.push_back(mk(1,1,5,1,1, 0,0,0));
    tbl_one.push_back(mk(1,0,5,1,0, 0,0,0));
    tbl_one.push_back(mk(1,1,1,1,0, 1,1,0));
    tbl_one.push_back(mk(1,0,0,1,1, 0,0,0));
    tbl_one.push_back(mk(1,1,1,1,0, 1,1,0));
    tbl_one.push_back(mk(1,0,0,1,0, 0,0,1));
    tbl_one.push_back(mk(1,0,0,1,0, 0,0,0));

    foreach (tbl_one[i]) begin
      apply(tbl_one[i].aclr, tbl_one[i].start, tbl_one[i].load, tbl_one[i].en, tbl_one[i].abort, 1'b0);
      check($sformatf("one[%0d].Q", i),    32'(bus0.Q),    32'(tbl_one[i].q));
      check($sformatf("one[%0d].busy", i), 32'(bus0.busy), 32'(tbl_one[i].busy));
      check($sformatf("one[%0d].done", i), 32'(bus0.done), 32'(tbl_one[i].done));
    end

    // periodic instance: load 2 -> 2,1,0,2,1,0 with done at each 0, then abort
    tbl_auto.push_back(mk(0,0,0,0,0, 0,0,0));
    tbl_auto.push_back(mk(1,1,2,1,0, 2,1,0));
    tbl_auto.push_back(mk(1,0,0,1,0, 1,1,0));
    tbl_auto.push_back(mk(1,0,0,1,0, 0,1,1));
    tbl_auto.push_back(mk(1,0,0,1,0, 2,1,0));
    tbl_auto.push_back(mk(1,1,7,0,0, 2,1,0));
    tbl_auto.push_back(mk(1,0,0,1,0, 1,1,0));
    tbl_auto.push_back(mk(1,0,0,1,0, 0,1,1));
    tbl_auto.push_back(mk(1,0,0,0,0, 0,1,0));
    tbl_auto.push_back(mk(1,0,0,1,0, 2,1,0));
    tbl_auto.push_back(mk(1,0,0,1,1, 0,0,0));
    tbl_auto.push_back(mk(1,0,0,1,0, 0,0,0));
    tbl_auto.push_back(mk(1,1,0,1,0, 0,0,1));
    tbl_auto.push_back(mk(1,0,0,1,0, 0,0,0));

    foreach (tbl_auto[i]) begin
      apply(tbl_auto[i].aclr, tbl_auto[i].start, tbl_auto[i].load, tbl_auto[i].en, tbl_auto[i].abort, 1'b0);
      check($sformatf("auto[%0d].Q", i),    32'(bus1.Q),    32'(tbl_auto[i].q));
      check($sformatf("auto[%0d].busy", i), 32'(bus1.busy), 32'(tbl_auto[i].busy));
      check($sformatf("auto[%0d].done", i), 32'(bus1.done), 32'(tbl_auto[i].done));
    end

    // resynchronise both models with a reset, then randomized traffic
    apply(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 2000; c++) begin
      logic         r_a, r_s, r_e, r_ab;
      logic [N-1:0] r_lv;
      r_a  = ($urandom_range(0, 63) != 0);
      r_s  = ($urandom_range(0, 3) == 0);
      r_e  = ($urandom_range(0, 2) != 0);
      r_ab = ($urandom_range(0, 24) == 0);
      r_lv = N'($urandom_range(0, 15));
      apply(r_a, r_s, r_lv, r_e, r_ab, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
